pc_sequencer: RTL

Program-counter sequencer for the single-cycle core; sits directly upstream of the 8-entry return-address stack. Each cycle it selects the next 12-bit PC from sequential, branch, jump, call and return sources. On call it drives the stack push with the return address. On return it drives the stack pop and stalls fetch until the popped address is loaded. An optional guard tracks stack depth and flags overflow/underflow faults.

---
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding the return-address stack: picks the next PC from
// sequential/branch/jump/call/return sources. Optional depth guard: define PC_SEQ_GUARD_EN.
module pc_sequencer #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ret,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [WIDTH-1:0] stack_pop_data,
`ifdef PC_SEQ_GUARD_EN
  input  logic             stack_overflow,
`endif
  output logic             push_sig,
  output logic [WIDTH-1:0] push_data,
  output logic             pop_sig,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             fault
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);

`ifdef PC_SEQ_GUARD_EN
  typedef enum logic [1:0] {S_RUN, S_RET_WAIT, S_FAULT} state_t;
`else
  typedef enum logic {S_RUN, S_RET_WAIT} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_br;

  // Carries out of the top bit are dropped, so all-ones + 1 wraps to zero.
  assign w_pc_inc = r_pc + WIDTH'(1);
  assign w_pc_br  = w_pc_inc + br_offset;

`ifdef PC_SEQ_GUARD_EN
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_depth;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);
`endif

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    push_sig     = 1'b0;
    push_data    = '0;
    pop_sig      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
`ifdef PC_SEQ_GUARD_EN
          if (stack_overflow) begin
            w_state_next = S_FAULT;
          end else
`endif
          if (!stall) begin
            if (ret) begin
`ifdef PC_SEQ_GUARD_EN
              if (w_empty) begin
                w_state_next = S_FAULT;
              end else
`endif
              begin
                pop_sig      = 1'b1;
                w_state_next = S_RET_WAIT;
              end
            end else if (call) begin
`ifdef PC_SEQ_GUARD_EN
              if (w_full) begin
                w_state_next = S_FAULT;
              end else
`endif
              begin
                push_sig  = 1'b1;
                push_data = w_pc_inc;
                w_pc_next = call_addr;
              end
            end else if (jmp) begin
              w_pc_next = jmp_addr;
            end else if (br_taken) begin
              w_pc_next = w_pc_br;
            end else begin
              w_pc_next = w_pc_inc;
            end
          end
        end
        // The return always completes: stall and new requests are not looked at here.
        S_RET_WAIT: begin
          w_pc_next    = stack_pop_data;
          w_state_next = S_RUN;
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC_W;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

`ifdef PC_SEQ_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
    end else if (push_sig) begin
      r_depth <= r_depth + DW'(1);
    end else if (pop_sig) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign fault = (r_state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  assign pc       = r_pc;
  assign pc_valid = (r_state == S_RUN);

endmodule
